// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, response queue to decode.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
`endif
  output logic [31:0] out_pc_plus4
);

  localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam ptr_t PTR_ZERO = ptr_t'(1'b0);
  localparam ptr_t PTR_ONE  = ptr_t'(1'b1);
  localparam cnt_t CNT_ZERO = cnt_t'(1'b0);
  localparam cnt_t CNT_ONE  = cnt_t'(1'b1);
  localparam cnt_t DEPTH_C  = cnt_t'(QUEUE_DEPTH);

  logic [31:0] pc_r;
  cnt_t        outstanding_r;
  cnt_t        drop_cnt_r;
  cnt_t        q_count_r;
  ptr_t        q_head_r;
  ptr_t        q_tail_r;
  ptr_t        af_head_r;
  ptr_t        af_tail_r;
  logic [31:0] q_inst_r [QUEUE_DEPTH];
  logic [31:0] q_pc_r   [QUEUE_DEPTH];
  logic [31:0] af_pc_r  [QUEUE_DEPTH];

  logic        out_valid_s;
  logic        pop_s;
  logic        req_s;
  logic        accept_s;
  logic        drop_s;
  logic        push_s;
  logic [CW:0] used_s;
  cnt_t        outstanding_next_s;
  cnt_t        q_count_next_s;

  // Handshake decode and the request credit check
  always_comb begin
    out_valid_s        = 1'b0;
    pop_s              = 1'b0;
    used_s             = {(CW+1){1'b0}};
    req_s              = 1'b0;
    accept_s           = 1'b0;
    drop_s             = 1'b0;
    push_s             = 1'b0;
    outstanding_next_s = outstanding_r;
    q_count_next_s     = q_count_r;

    out_valid_s = !rst && (q_count_r != CNT_ZERO);
    pop_s       = out_valid_s && out_ready;
    // In-flight requests plus buffered words must leave room for every response.
    used_s      = {1'b0, outstanding_r} + {1'b0, q_count_r} - {{CW{1'b0}}, pop_s};
    req_s       = !rst && !redirect_valid && (used_s < {1'b0, DEPTH_C});
    accept_s    = req_s && imem_ready;
    drop_s      = imem_rvalid && (drop_cnt_r != CNT_ZERO);
    push_s      = imem_rvalid && (drop_cnt_r == CNT_ZERO) && !redirect_valid;

    outstanding_next_s = outstanding_r + (accept_s ? CNT_ONE : CNT_ZERO)
                                       - (imem_rvalid ? CNT_ONE : CNT_ZERO);
    q_count_next_s     = q_count_r + (push_s ? CNT_ONE : CNT_ZERO)
                                   - (pop_s ? CNT_ONE : CNT_ZERO);
  end

  // PC, credit counters, address FIFO and instruction queue
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      outstanding_r <= CNT_ZERO;
      drop_cnt_r    <= CNT_ZERO;
      q_count_r     <= CNT_ZERO;
      q_head_r      <= PTR_ZERO;
      q_tail_r      <= PTR_ZERO;
      af_head_r     <= PTR_ZERO;
      af_tail_r     <= PTR_ZERO;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_inst_r[i] <= 32'h0000_0000;
        q_pc_r[i]   <= 32'h0000_0000;
        af_pc_r[i]  <= 32'h0000_0000;
      end
    end else if (redirect_valid) begin
      // Every request still in flight now belongs to the abandoned path.
      pc_r          <= redirect_pc & 32'hFFFF_FFFC;
      outstanding_r <= outstanding_next_s;
      drop_cnt_r    <= outstanding_next_s;
      q_count_r     <= CNT_ZERO;
      q_head_r      <= PTR_ZERO;
      q_tail_r      <= PTR_ZERO;
      af_head_r     <= PTR_ZERO;
      af_tail_r     <= PTR_ZERO;
    end else begin
      outstanding_r <= outstanding_next_s;
      q_count_r     <= q_count_next_s;
      if (accept_s) begin
        pc_r               <= pc_r + 32'd4;
        af_pc_r[af_tail_r] <= pc_r;
        af_tail_r          <= af_tail_r + PTR_ONE;
      end
      if (drop_s) begin
        drop_cnt_r <= drop_cnt_r - CNT_ONE;
      end
      if (push_s) begin
        q_inst_r[q_tail_r] <= imem_rdata;
        q_pc_r[q_tail_r]   <= af_pc_r[af_head_r];
        q_tail_r           <= q_tail_r + PTR_ONE;
        af_head_r          <= af_head_r + PTR_ONE;
      end
      if (pop_s) begin
        q_head_r <= q_head_r + PTR_ONE;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_r;
  logic [31:0] perf_stall_r;

  // Decode-side throughput counters, free-running and wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_r <= 32'h0000_0000;
      perf_stall_r   <= 32'h0000_0000;
    end else begin
      if (pop_s) begin
        perf_fetched_r <= perf_fetched_r + 32'd1;
      end
      if (!out_valid_s) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_r;
  assign perf_stall   = perf_stall_r;
`endif

  assign imem_req     = req_s;
  assign imem_addr    = pc_r;
  assign out_valid    = out_valid_s;
  assign out_inst     = q_inst_r[q_head_r];
  assign out_pc       = q_pc_r[q_head_r];
  assign out_pc_plus4 = q_pc_r[q_head_r] + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order random-latency memory, expected-stream model, directed cases.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int          QD  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched(perf_fetched), .perf_stall(perf_stall),
`endif
    .out_pc_plus4(out_pc_plus4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        pend[$];
  int          cyc = 0;
  int          last_due = 0;
  int          errors = 0;
  int          checks = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          ready_pct = 100;
  int          pops = 0;
  logic [31:0] fetch_pc_m;
  logic [31:0] exp_pc_m;
  logic        hold_pending = 1'b0;
  logic [31:0] hold_addr = 32'h0;
  logic        s_req, s_acc, s_valid, s_rvalid;
  logic [31:0] s_addr, s_pc, s_pc4, s_inst;
  logic [31:0] pf_m = 32'h0;
  logic [31:0] ps_m = 32'h0;

  // Memory content: a bijection of the address, so a stale word never matches a new pc.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycle();
    int  lat;
    int  due;
    logic pop;
    if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    imem_ready = ($urandom_range(99) < ready_pct);
    @(negedge clk);
    s_req = imem_req; s_addr = imem_addr; s_valid = out_valid; s_rvalid = imem_rvalid;
    s_pc = out_pc; s_pc4 = out_pc_plus4; s_inst = out_inst;
    s_acc = imem_req && imem_ready;
    pop = 1'b0;
    if (rst) begin
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    end else begin
      if (redirect_valid) chk("redirect_req", {31'd0, imem_req}, 32'd0);
      if (hold_pending && imem_req) chk("addr_hold", imem_addr, hold_addr);
      if (imem_req) chk("fetch_addr", imem_addr, fetch_pc_m);
      if (out_valid) chk("pc_plus4", out_pc_plus4, out_pc + 32'd4);
      pop = out_valid && out_ready;
      if (pop) begin
        chk("out_pc", out_pc, exp_pc_m);
        chk("out_inst", out_inst, word_of(exp_pc_m));
        exp_pc_m = exp_pc_m + 32'd4;
        pops++;
      end
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched", perf_fetched, pf_m);
      chk("perf_stall", perf_stall, ps_m);
`endif
    end
    // Model update for the coming edge.
    if (rst) begin
      pend.delete();
      last_due   = cyc;
      fetch_pc_m = RPC;
      exp_pc_m   = RPC;
      pf_m       = 32'h0;
      ps_m       = 32'h0;
    end else begin
      if (pop) pf_m = pf_m + 32'd1;
      if (!out_valid) ps_m = ps_m + 32'd1;
      if (imem_rvalid) void'(pend.pop_front());
      if (s_acc) begin
        lat = $urandom_range(lat_max, lat_min);
        due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        last_due = due;
        pend.push_back('{addr: imem_addr, due: due});
        chk("credit_inflight", 32'(pend.size() <= QD), 32'd1);
      end
      if (redirect_valid) begin
        fetch_pc_m = redirect_pc & 32'hFFFF_FFFC;
        exp_pc_m   = redirect_pc & 32'hFFFF_FFFC;
      end else if (s_acc) begin
        fetch_pc_m = fetch_pc_m + 32'd4;
      end
    end
    hold_pending = !rst && !redirect_valid && imem_req && !imem_ready;
    hold_addr    = imem_addr;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) cycle();
    rst = 1'b0;
  endtask

  initial begin
    int nacc;
    int found;
    int rand_pops;
    rst = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    @(posedge clk);
    #1;

    // 1-cycle memory, full throughput after reset.
    do_reset(3);
    cycle();
    chk("first_req", {31'd0, s_req}, 32'd1);
    chk("first_addr", s_addr, 32'h0000_0100);
    chk("c0_out_valid", {31'd0, s_valid}, 32'd0);
    cycle();
    chk("c1_out_valid", {31'd0, s_valid}, 32'd0);
    chk("c1_addr", s_addr, 32'h0000_0104);
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("stream_valid", {31'd0, s_valid}, 32'd1);
      chk("stream_pc", s_pc, 32'h0000_0100 + 32'(4 * k));
    end

    // Decoder stalled: only QUEUE_DEPTH requests, then drain in order.
    do_reset(1);
    out_ready = 1'b0;
    nacc = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      nacc += int'(s_acc);
    end
    chk("stall_req_count", 32'(nacc), 32'd2);
    chk("stall_req_off", {31'd0, s_req}, 32'd0);
    out_ready = 1'b1;
    cycle();
    chk("drain_pc0", s_pc, 32'h0000_0100);
    cycle();
    chk("drain_pc1", s_pc, 32'h0000_0104);

    // 3-cycle memory, two in flight, redirect to an unaligned target.
    do_reset(1);
    lat_min = 3; lat_max = 3;
    cycle();
    cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("redir_addr", s_addr, 32'h0000_0200);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      cycle();
      if (s_valid) found = 1;
    end
    chk("redir_found", 32'(found), 32'd1);
    chk("redir_pc", s_pc, 32'h0000_0200);
    chk("redir_inst", s_inst, word_of(32'h0000_0200));

    // Redirect coinciding with rvalid and a pop.
    lat_min = 1; lat_max = 1;
    do_reset(1);
    cycle();
    cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
    cycle();
    redirect_valid = 1'b0;
    chk("coincide_rvalid", {31'd0, s_rvalid}, 32'd1);
    chk("coincide_pop", {31'd0, s_valid}, 32'd1);
    cycle();
    chk("flush_empty", {31'd0, s_valid}, 32'd0);
    chk("flush_target", s_addr, 32'h0000_0400);
    chk("flush_req", {31'd0, s_req}, 32'd1);

    // Address wrap at the top of the space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_addr1", s_addr, 32'h0000_0000);
    cycle();
    chk("wrap_valid", {31'd0, s_valid}, 32'd1);
    chk("wrap_pc", s_pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", s_pc4, 32'h0000_0000);

    // Randomized traffic against the stream model.
    rand_pops = pops;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) begin
        lat_min   = 1;
        lat_max   = 1 + $urandom_range(3);
        ready_pct = 40 + $urandom_range(60);
      end
      if ($urandom_range(999) < 3) do_reset(1 + $urandom_range(1));
      out_ready      = ($urandom_range(99) < 70);
      redirect_valid = ($urandom_range(99) < 4);
      redirect_pc    = $urandom;
      cycle();
      redirect_valid = 1'b0;
    end
    chk("random_progress", 32'((pops - rand_pops) > 200), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
